output_buffer: RTL and testbench
================================

# output_buffer

Drain-side counterpart of the input buffer. It accepts the column-skewed partial-sum stream leaving the bottom of the systolic array and realigns each result row so all columns line up. Aligned rows go into a row FIFO, which a downstream consumer pops with a read/valid handshake. It sits in the datapath directly on the systolic `of_data` bus and reports completion once a full tile of `A_rows` rows has been captured.

## Interface
Parameters (defaults taken from Config):
- COLS, sys_cols: number of array columns (≥1)
- PW, P_BITWIDTH: bits per partial-sum element
- DEPTH, A_rows: FIFO depth in rows, and the tile size used by `of_done`

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of pipeline, FIFO, counters and flags
- i_valid  in  1  column 0 of a new result row is on `i_data[0]` this cycle
- i_data  in  [COLS][PW]  systolic `of_data`; column c valid c cycles after `i_valid`
- read  in  1  consumer pop request
- o_valid  out  1  FIFO non-empty; `o_data` holds the head row
- o_data  out  [COLS][PW]  head row, columns aligned
- full  out  1  FIFO holds DEPTH rows
- empty  out  1  FIFO holds 0 rows
- of_done  out  1  DEPTH rows pushed since last clr/reset
- overflow  out  1  sticky; a push was dropped

## Operation
- Deskew: column c passes through a delay of COLS-1-c registers, so column COLS-1 has no delay. `i_valid` passes through a COLS-1 stage valid shift register.
- When the delayed valid is high, the aligned row is pushed into the FIFO. The delay line does not gate data, so row alignment depends only on valid timing. Back-to-back `i_valid` on every cycle is supported.
- FIFO: circular, DEPTH entries. `wr_ptr`/`rd_ptr` wrap from DEPTH-1 to 0. The occupancy count is $clog2(DEPTH+1) bits.
- `o_valid` = !empty. `o_data` = mem[rd_ptr] (combinational read).
- Pop: `read && o_valid` advances `rd_ptr` at the edge. `read` while empty is ignored; no state changes.
- Push while full without a pop: the row is dropped and `overflow` is set (sticky until clr/reset). The count is unchanged.
- Push and pop in the same cycle: both are performed, count unchanged. This includes the full case: the push is accepted and there is no overflow.
- Row counter: increments on each accepted push and saturates at DEPTH. `of_done` = (row counter == DEPTH).
- clr: zeroes the valid shift register, pointers, count, row counter and `overflow`. Delay-line data registers need not clear. clr takes priority over push and pop in the same cycle.
- Data is passed through unmodified. There is no arithmetic on partial sums.

## Timing
- Reset (rst=0, async): `o_valid`=0, `empty`=1, `full`=0, `of_done`=0, `overflow`=0, `o_data`=don't care. All pointers, counters and the valid pipeline are 0.
- Reset deasserting mid-stream: rows already in the delay pipe are lost. The first push comes from an `i_valid` that occurs after reset release.
- Latency: `i_valid` at cycle t → push at the edge ending cycle t+COLS-1 → `o_valid`=1 during cycle t+COLS. For COLS=1, push at the edge ending cycle t and `o_valid` during t+1.
- `full`, `empty` and `of_done` are registered-state decodes and update the cycle after the push/pop edge.
- Throughput: one row per cycle in and out.

## Structure
- Config package additions: `typedef logic [sys_cols-1:0][P_BITWIDTH-1:0] out_row_t;` and a localparam `OB_CNT_W = $clog2(A_rows+1)`.
- Sub-module `skew_delay`: parameterized by depth (0 = wire) and width. Instantiate one per column in a generate loop with depth COLS-1-c.
- Keep FIFO and control inline in `output_buffer`.

## Test plan
Bench config: COLS=4, PW=32, DEPTH=4.
- Reset: hold rst=0 for 3 cycles, then release → `empty`=1, `o_valid`=0, `of_done`=0, `overflow`=0 with no input.
- Single row: `i_valid` at t, column c = 0x10+c at t+c → `o_valid` at t+4, `o_data` = {0x13,0x12,0x11,0x10}. After one `read`, `empty`=1.
- Burst: 4 back-to-back rows, row r col c = 16r+c, no reads → `full`=1 and `of_done`=1. Four pops return rows 0..3 in order and aligned.
- Overflow: FIFO full, a 5th row arrives with `read`=0 → `overflow`=1, count stays 4, and the head is still row 0.
- Simultaneous: FIFO full, a 5th row push coincides with `read`=1 → no overflow, count stays 4, and the new row is popped last.
- Mid-operation: assert rst=0 while 2 rows sit in the pipe and 2 in the FIFO → all outputs return to reset values immediately. Assert clr instead → same state one cycle later.

Source files
------------

// File: rtl/output_buffer_pkg.sv
// Shared types and sizing for the drain-side output buffer.
package output_buffer_pkg;
    localparam int sys_cols   = 4;
    localparam int P_BITWIDTH = 32;
    localparam int A_rows     = 4;

    localparam int OB_CNT_W = $clog2(A_rows + 1);

    typedef logic [sys_cols-1:0][P_BITWIDTH-1:0] out_row_t;
endpackage

// File: rtl/output_buffer_skew_delay.sv
// Fixed-length register delay for one column of the skewed stream; depth 0 is a wire.
module skew_delay #(
    parameter int DEPTH = 1,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    if (DEPTH == 0) begin : g_wire
        logic unused_clk;
        assign unused_clk = clk;
        assign q = d;
    end else begin : g_regs
        logic [DEPTH-1:0][W-1:0] pipe_q, pipe_d;

        always_comb begin
            pipe_d[0] = d;
            for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
        end

        // Pure data delay: alignment is governed by the valid pipe, so no reset needed.
        always_ff @(posedge clk) pipe_q <= pipe_d;

        assign q = pipe_q[DEPTH-1];
    end
endmodule

// File: rtl/output_buffer.sv
// Realigns column-skewed systolic result rows and queues them in a row FIFO.
module output_buffer
    import output_buffer_pkg::*;
#(
    parameter int COLS  = sys_cols,
    parameter int PW    = P_BITWIDTH,
    parameter int DEPTH = A_rows
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     i_valid,
    input  logic [COLS-1:0][PW-1:0]  i_data,
    input  logic                     read,
    output logic                     o_valid,
    output logic [COLS-1:0][PW-1:0]  o_data,
    output logic                     full,
    output logic                     empty,
    output logic                     of_done,
    output logic                     overflow
);
    localparam int STAGES = COLS - 1;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic [COLS-1:0][PW-1:0] row_aligned;
    logic                    push;

    for (genvar c = 0; c < COLS; c++) begin : g_col
        skew_delay #(.DEPTH(COLS - 1 - c), .W(PW)) u_dly (
            .clk (clk),
            .d   (i_data[c]),
            .q   (row_aligned[c])
        );
    end

    if (STAGES == 0) begin : g_vld_none
        assign push = i_valid;
    end else begin : g_vld_pipe
        logic [STAGES-1:0] vld_q, vld_d;

        always_comb begin
            vld_d    = vld_q << 1;
            vld_d[0] = i_valid;
            if (clr) vld_d = '0;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) vld_q <= '0;
            else      vld_q <= vld_d;
        end

        assign push = vld_q[STAGES-1];
    end

    logic [PW*COLS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d, row_cnt_q, row_cnt_d;
    logic               overflow_q, overflow_d;
    logic               do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        do_pop     = read && (count_q != '0);
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        do_push    = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d   = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d    = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        row_cnt_d  = (do_push && row_cnt_q != CNT_W'(DEPTH)) ? row_cnt_q + CNT_W'(1) : row_cnt_q;
        overflow_d = overflow_q || (push && !do_push);
        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            row_cnt_d  = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            row_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            row_cnt_q  <= row_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_ptr_q] <= row_aligned;
    end

    assign o_data   = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign o_valid  = !empty;
    assign of_done  = (row_cnt_q == CNT_W'(DEPTH));
    assign overflow = overflow_q;
endmodule

// File: tb/tb_output_buffer.sv
// Directed bench for output_buffer: deskew, FIFO ordering, overflow, clear and reset.
module tb_output_buffer;
    import output_buffer_pkg::*;

    localparam int COLS  = 4;
    localparam int PW    = 32;
    localparam int DEPTH = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    clr = 1'b0;
    logic                    i_valid = 1'b0;
    logic                    read = 1'b0;
    logic [COLS-1:0][PW-1:0] i_data = '0;
    logic                    o_valid, full, empty, of_done, overflow;
    logic [COLS-1:0][PW-1:0] o_data;

    int       checks = 0;
    int       errors = 0;
    out_row_t send [8];

    output_buffer #(.COLS(COLS), .PW(PW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .i_valid  (i_valid),
        .i_data   (i_data),
        .read     (read),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .full     (full),
        .empty    (empty),
        .of_done  (of_done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [COLS*PW-1:0] obs, input logic [COLS*PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic out_row_t mk_row(input logic [PW-1:0] base);
        out_row_t r;
        for (int c = 0; c < COLS; c++) r[c] = base + PW'(c);
        return r;
    endfunction

    // Drive send[0..n-1] skewed: row r column c appears in cycle r+c.
    task automatic stream(input int n, input int stop, input int read_k, input bit lat);
        for (int k = 0; k < n + COLS - 1 && k < stop; k++) begin
            i_valid = (k < n);
            read    = (k == read_k);
            for (int c = 0; c < COLS; c++) begin
                if (k - c >= 0 && k - c < n) i_data[c] = send[k-c][c];
                else                         i_data[c] = 32'hDEAD0000 | PW'(c);
            end
            if (lat && k == n + COLS - 2) chk("latency_pre_valid", o_valid, 0);
            tick();
        end
        i_valid = 1'b0;
        read    = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input out_row_t exp);
        chk({tag, "_valid"}, o_valid, 1);
        chk(tag, o_data, exp);
        read = 1'b1;
        tick();
        read = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic load_burst(input logic [PW-1:0] base);
        for (int r = 0; r < 4; r++) send[r] = mk_row(base + PW'(16 * r));
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("rst_empty", empty, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_full", full, 0);
        chk("rst_done", of_done, 0);
        chk("rst_ovf", overflow, 0);

        send[0] = mk_row(32'h10);
        stream(1, 99, -1, 1'b1);
        chk("single_valid", o_valid, 1);
        chk("single_data", o_data, {32'h13, 32'h12, 32'h11, 32'h10});
        chk("single_done", of_done, 0);
        read = 1'b1;
        tick();
        read = 1'b0;
        chk("single_empty", empty, 1);

        pulse_clr();
        chk("clr_done", of_done, 0);
        load_burst(32'h0);
        stream(4, 99, -1, 1'b0);
        chk("burst_full", full, 1);
        chk("burst_done", of_done, 1);
        for (int r = 0; r < 4; r++) pop_chk("burst_pop", mk_row(PW'(16 * r)));
        chk("burst_empty", empty, 1);
        chk("burst_done_hold", of_done, 1);

        stream(4, 99, -1, 1'b0);
        send[0] = mk_row(32'h40);
        stream(1, 99, -1, 1'b0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_full", full, 1);
        chk("ovf_head", o_data, mk_row(32'h0));
        load_burst(32'h0);
        for (int r = 0; r < 4; r++) pop_chk("ovf_pop", mk_row(PW'(16 * r)));
        chk("ovf_drained", empty, 1);

        pulse_clr();
        chk("clr_ovf", overflow, 0);
        chk("clr_empty", empty, 1);

        stream(4, 99, -1, 1'b0);
        send[0] = mk_row(32'h50);
        stream(1, 99, 3, 1'b0);
        chk("sim_ovf", overflow, 0);
        chk("sim_full", full, 1);
        for (int r = 1; r < 4; r++) pop_chk("sim_pop", mk_row(PW'(16 * r)));
        pop_chk("sim_pop_new", mk_row(32'h50));
        chk("sim_empty", empty, 1);

        load_burst(32'h60);
        stream(4, 5, -1, 1'b0);
        chk("mid_pre_valid", o_valid, 1);
        chk("mid_pre_full", full, 0);
        rst = 1'b0;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_empty", empty, 1);
        chk("arst_full", full, 0);
        chk("arst_done", of_done, 0);
        chk("arst_ovf", overflow, 0);
        tick();
        rst = 1'b1;
        repeat (5) tick();
        chk("arst_pipe_lost", empty, 1);

        stream(4, 99, -1, 1'b0);
        send[0] = mk_row(32'h70);
        stream(1, 99, -1, 1'b0);
        chk("pre_clr_ovf", overflow, 1);
        pop_chk("pre_clr_pop0", mk_row(32'h60));
        pop_chk("pre_clr_pop1", mk_row(32'h70));
        load_burst(32'h80);
        stream(2, 3, -1, 1'b0);
        pulse_clr();
        chk("mclr_valid", o_valid, 0);
        chk("mclr_empty", empty, 1);
        chk("mclr_full", full, 0);
        chk("mclr_done", of_done, 0);
        chk("mclr_ovf", overflow, 0);
        repeat (5) tick();
        chk("mclr_pipe_lost", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
